// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction loader and the control-unit decoder:
// opcodes, R-type functs, loader command kinds and loader error codes.
package mips_isa_pkg;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // Encodings 6 and 7 are deliberately left unnamed: they are illegal kinds.
   typedef enum logic [2:0] {
      KindLw    = 3'd0,
      KindSw    = 3'd1,
      KindRtype = 3'd2,
      KindBeq   = 3'd3,
      KindAddi  = 3'd4,
      KindJ     = 3'd5
   } cmd_kind_e;

   typedef enum logic [1:0] {
      ErrNone     = 2'b00,
      ErrIllegal  = 2'b01,
      ErrOverflow = 2'b10
   } err_e;

endpackage

// File: rtl/instr_encoder.sv
// Combinational field packer: command kind plus register/immediate fields to a 32-bit
// MIPS instruction word, with a flag for kinds that have no encoding.
module instr_encoder
   import mips_isa_pkg::*;
(
   input  logic [2:0]  kind_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [5:0]  funct_i,
   input  logic [15:0] imm_i,
   input  logic [25:0] target_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

   always_comb begin
      word_o    = '0;
      illegal_o = 1'b0;
      case (kind_i)
         KindLw:    word_o = {OP_LW, rs_i, rt_i, imm_i};
         KindSw:    word_o = {OP_SW, rs_i, rt_i, imm_i};
         KindRtype: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b00000, funct_i};
         KindBeq:   word_o = {OP_BEQ, rs_i, rt_i, imm_i};
         KindAddi:  word_o = {OP_ADDI, rs_i, rt_i, imm_i};
         KindJ:     word_o = {OP_J, target_i};
         default:   illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot-time instruction loader: encodes field-level commands and writes them sequentially
// into instruction memory while holding the CPU in reset. Define ZERO_FILL_EN to pad the
// unused tail of memory with FILL_WORD after the last command.
module instr_mem_loader
   import mips_isa_pkg::*;
#(
   parameter int unsigned ADDR_W    = 6,
   parameter logic [31:0] FILL_WORD = 32'h0000_0000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              CmdValid,
   output logic              CmdReady,
   input  logic [2:0]        CmdKind,
   input  logic [4:0]        CmdRs,
   input  logic [4:0]        CmdRt,
   input  logic [4:0]        CmdRd,
   input  logic [5:0]        CmdFunct,
   input  logic [15:0]       CmdImm,
   input  logic [25:0]       CmdTarget,
   input  logic              CmdLast,
   output logic              IMWE,
   output logic [ADDR_W-1:0] IMAddr,
   output logic [31:0]       IMWData,
   output logic              CPU_RST,
   output logic              Done,
   output logic [1:0]        Err,
   output logic [ADDR_W:0]   Count
);

   localparam int unsigned       Depth    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LastSlot = ADDR_W'(Depth - 1);
   localparam logic [ADDR_W:0]   CountMax = (ADDR_W + 1)'(Depth);

`ifdef ZERO_FILL_EN
   typedef enum logic [2:0] {StIdle, StLoad, StFill, StDone, StErr} state_e;
`else
   typedef enum logic [2:0] {StIdle, StLoad, StDone, StErr} state_e;
`endif

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   err_e                err_q, err_d;
   logic                imwe_q, imwe_d;
   logic [ADDR_W-1:0]   imaddr_q, imaddr_d;
   logic [31:0]         imwdata_q, imwdata_d;

   logic [31:0] enc_word;
   logic        enc_illegal;
   logic        accept;
   logic        restart;
   logic        at_last_slot;
   logic        fill_active;

   instr_encoder u_encoder (
      .kind_i    (CmdKind),
      .rs_i      (CmdRs),
      .rt_i      (CmdRt),
      .rd_i      (CmdRd),
      .funct_i   (CmdFunct),
      .imm_i     (CmdImm),
      .target_i  (CmdTarget),
      .word_o    (enc_word),
      .illegal_o (enc_illegal)
   );

   assign accept       = CmdValid && (state_q == StLoad);
   assign restart      = START && (state_q inside {StIdle, StDone, StErr});
   assign at_last_slot = (ptr_q == LastSlot);

`ifdef ZERO_FILL_EN
   assign fill_active = (state_q == StFill);
`else
   assign fill_active = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         count_q   <= '0;
         err_q     <= ErrNone;
         imwe_q    <= 1'b0;
         imaddr_q  <= '0;
         imwdata_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         count_q   <= count_d;
         err_q     <= err_d;
         imwe_q    <= imwe_d;
         imaddr_q  <= imaddr_d;
         imwdata_q <= imwdata_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (START) state_d = StLoad;
         end
         StLoad: begin
            if (accept) begin
               if (enc_illegal) begin
                  state_d = StErr;
               end else if (CmdLast) begin
`ifdef ZERO_FILL_EN
                  state_d = at_last_slot ? StDone : StFill;
`else
                  state_d = StDone;
`endif
               end else if (at_last_slot) begin
                  state_d = StErr;
               end
            end
         end
`ifdef ZERO_FILL_EN
         StFill: begin
            if (at_last_slot) state_d = StDone;
         end
`endif
         StDone, StErr: begin
            if (START) state_d = StLoad;
         end
         default: state_d = StIdle;
      endcase
   end

   // Write port, pointer, count and error bookkeeping
   always_comb begin
      ptr_d     = ptr_q;
      count_d   = count_q;
      err_d     = err_q;
      imwe_d    = 1'b0;
      imaddr_d  = imaddr_q;
      imwdata_d = imwdata_q;

      if (restart) begin
         ptr_d   = '0;
         count_d = '0;
         err_d   = ErrNone;
      end

      if (accept) begin
         if (enc_illegal) begin
            err_d = ErrIllegal;
         end else begin
            imwe_d    = 1'b1;
            imaddr_d  = ptr_q;
            imwdata_d = enc_word;
            ptr_d     = ptr_q + 1'b1;
            count_d   = (count_q == CountMax) ? count_q : count_q + 1'b1;
            // The word in the final slot is still written; only a missing CmdLast is an error.
            if (!CmdLast && at_last_slot) err_d = ErrOverflow;
         end
      end

      if (fill_active) begin
         imwe_d    = 1'b1;
         imaddr_d  = ptr_q;
         imwdata_d = FILL_WORD;
         ptr_d     = ptr_q + 1'b1;
      end
   end

   // State-decoded outputs
   always_comb begin
      CmdReady = (state_q == StLoad);
      Done     = (state_q == StDone);
      CPU_RST  = (state_q != StDone);
      IMWE     = imwe_q;
      IMAddr   = imaddr_q;
      IMWData  = imwdata_q;
      Err      = err_q;
      Count    = count_q;
   end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer-side counterpart of the single-cycle opcode decoder. It accepts field-level instruction commands over a valid/ready handshake and encodes each one into a 32-bit MIPS word (LW, SW, R-type, BEQ, ADDI, J). It writes the words sequentially into the instruction memory write port and holds the CPU in reset until loading completes. It sits between the testbench/boot source and instruction memory.

Parameters:
ADDR_W, 6, instruction-memory word-address width; DEPTH = 2**ADDR_W words
FILL_WORD, 32'h0000_0000, word written to unused slots when ZERO_FILL_EN is defined (the MIPS NOP)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
START  input  1  one-cycle pulse that begins a load session
CmdValid  input  1  command valid
CmdReady  output  1  loader can accept a command
CmdKind  input  3  0=LW 1=SW 2=RTYPE 3=BEQ 4=ADDI 5=J; 6 and 7 are illegal
CmdRs, CmdRt, CmdRd  input  5 each  register fields
CmdFunct  input  6  R-type funct (shamt is always 0)
CmdImm  input  16  immediate/offset
CmdTarget  input  26  J target field
CmdLast  input  1  marks the final command
IMWE  output  1  instruction-memory write enable
IMAddr  output  ADDR_W  word address (PC byte address = IMAddr<<2)
IMWData  output  32  encoded instruction
CPU_RST  output  1  holds the CPU in reset
Done  output  1  load completed
Err  output  2  01=illegal kind, 10=overflow, 00=none
Count  output  ADDR_W+1  words written from commands

Behaviour:
- Reset state: IDLE, CmdReady=0, IMWE=0, IMAddr=0, IMWData=0, CPU_RST=1, Done=0, Err=00, Count=0.
- A RST during any state returns the block to this state in the same cycle. Memory contents written so far are left as-is and are unspecified to the CPU.
- States:
  - IDLE: wait for START, then go to LOAD.
  - LOAD: CmdReady=1.
  - FILL: present only with ZERO_FILL_EN.
  - DONE: Done=1, CPU_RST=0.
  - ERR: CPU_RST=1, CmdReady=0.
- Handshake: a transfer occurs when CmdValid && CmdReady on a clock edge. Commands are never dropped while CmdReady=1.
- Write latency: for an accepted legal command, IMWE=1 with the encoded IMWData in the cycle after the handshake, at the current write pointer. The pointer and Count then increment.
- Throughput: one command per cycle. IMWE is a registered one-cycle pulse per word.
- Encoding (all fields concatenated MSB first):
  - LW = {100011, rs, rt, imm}
  - SW = {101011, rs, rt, imm}
  - RTYPE = {000000, rs, rt, rd, 00000, funct}
  - BEQ = {000100, rs, rt, imm}
  - ADDI = {001000, rs, rt, imm}
  - J = {000010, target}
- Illegal kind (6 or 7): the command is accepted but not written. Set Err=01 and go to ERR the next cycle.
- CmdLast with a legal kind: that word is written, then the FSM goes to DONE (or FILL).
- Full: if the accepted command lands in slot DEPTH-1 without CmdLast, the word is still written. Then Err=10, go to ERR.
- CmdLast at slot DEPTH-1 is legal and goes to DONE.
- START while in LOAD or FILL is ignored.
- START while in DONE or ERR restarts the session:
  - clears Err, Done, Count and the pointer
  - asserts CPU_RST in the next cycle
  - enters LOAD
- Simultaneous RST and START: RST wins.
- Count saturates at DEPTH.

Optional Feature:
- Macro: ZERO_FILL_EN.
- Defined: after CmdLast, the FSM enters FILL. It writes FILL_WORD, one word per cycle, from the next pointer up to DEPTH-1 with IMWE=1, then goes to DONE. CmdReady=0 and CPU_RST=1 during FILL. Count does not include fill words.
- If CmdLast landed at slot DEPTH-1, FILL is skipped.
- Undefined: there is no FILL state, and unused slots are untouched.

Decomposition:
- Shared package mips_isa_pkg:
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J
  - funct constants (FN_ADD=100000 etc.)
  - CmdKind enum
  - Err codes
- These are the same opcode constants the control unit decodes.
- Sub-module instr_encoder: a purely combinational field packer (kind + fields -> 32-bit word + illegal flag). The loader registers its output.

Test Plan:
- Encoding sweep:
  - LW rs=0 rt=8 imm=0x0004 -> 0x8C080004
  - SW rs=0 rt=8 imm=0x0008 -> 0xAC080008
  - RTYPE rs=8 rt=9 rd=10 funct=0x20 -> 0x01095020
  - BEQ rs=8 rt=9 imm=0xFFFF -> 0x1109FFFF
  - ADDI rs=0 rt=8 imm=5 -> 0x20080005
  - J target=0x10 -> 0x08000010
  - Each appears on IMWData with IMWE=1 one cycle after its handshake, at addresses 0..5. After CmdLast: Done=1, CPU_RST=0, Count=6.
- Back-to-back plus gaps: 4 commands with CmdValid toggling every other cycle -> exactly 4 IMWE pulses at addresses 0..3, with no duplicates or drops.
- Illegal kind 7 as the 3rd command -> addresses 0..1 written, no third write, Err=01, CPU_RST stays 1. A later START -> Err=00, pointer=0.
- Overflow with ADDR_W=2: 4 commands without CmdLast -> all 4 written, then Err=10 and ERR state. A second run where the 4th command has CmdLast -> Done=1, Err=00.
- RST asserted mid-LOAD after 2 writes -> next cycle IDLE, IMAddr=0, Count=0, CPU_RST=1, CmdReady=0.
- ZERO_FILL_EN, ADDR_W=3, 3 commands ending in CmdLast -> 5 FILL_WORD writes at addresses 3..7 on consecutive cycles, then Done=1, Count=3.
